// File: rtl/lbfgs_result_unloader.sv
// Captures an L-BFGS result vector in one cycle and streams it out one word per
// valid/ready handshake, followed by a one-cycle XOR checksum pulse.
module lbfgs_result_unloader #(
    parameter int NUM_WORDS  = 52,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_LBFGS,
    input  logic                  valid_LBFGS,
    input  logic [DATA_WIDTH-1:0] result_LBFGS [NUM_WORDS],
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  chk_valid,
    output logic [DATA_WIDTH-1:0] chk_data,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   index_reg;
    logic [DATA_WIDTH-1:0]   acc_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic                    out_valid_reg;
    logic                    out_last_reg;
    logic                    busy_reg;
    logic                    chk_valid_reg;
    logic [DATA_WIDTH-1:0]   chk_data_reg;
    logic                    overrun_reg;
    logic [DATA_WIDTH-1:0]   buffer_reg [NUM_WORDS];

    logic                    capture;
    logic                    transfer;
    logic [ADDR_WIDTH-1:0]   next_index;

    assign capture    = (state_reg == IDLE) && valid_LBFGS;
    assign transfer   = (state_reg == SEND) && out_ready;
    assign next_index = index_reg + ADDR_WIDTH'(1);

    // The buffer carries no reset: it is only observed after a capture fills it.
    always_ff @(posedge clk) begin
        if (capture) begin
            buffer_reg <= result_LBFGS;
        end
    end

    always_ff @(posedge clk or negedge rst_LBFGS) begin
        if (!rst_LBFGS) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            chk_valid_reg <= 1'b0;
            chk_data_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_LBFGS) begin
                        state_reg     <= SEND;
                        index_reg     <= '0;
                        acc_reg       <= '0;
                        chk_data_reg  <= '0;
                        out_data_reg  <= result_LBFGS[0];
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (NUM_WORDS == 1);
                        busy_reg      <= 1'b1;
                    end
                end
                SEND: begin
                    // Includes a pulse coinciding with the final transfer.
                    if (valid_LBFGS) begin
                        overrun_reg <= 1'b1;
                    end
                    if (transfer) begin
                        acc_reg <= acc_reg ^ out_data_reg;
                        if (index_reg == LAST_IDX) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            chk_valid_reg <= 1'b1;
                            chk_data_reg  <= acc_reg ^ out_data_reg;
                        end else begin
                            index_reg    <= next_index;
                            out_data_reg <= buffer_reg[next_index];
                            out_last_reg <= (next_index == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    if (valid_LBFGS) begin
                        overrun_reg <= 1'b1;
                    end
                    state_reg     <= IDLE;
                    chk_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    chk_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_addr  = index_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign chk_valid = chk_valid_reg;
    assign chk_data  = chk_data_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_lbfgs_result_unloader.sv
// Directed frame table plus reset-mid-frame and randomized frames for the
// result unloader; every word, address and checksum is checked against the bench model.
module tb_lbfgs_result_unloader;

    localparam int NW = 52;
    localparam int DW = 64;
    localparam int AW = 6;

    localparam int PAT_INC   = 0;  // word[i] = i+1
    localparam int PAT_SHIFT = 1;  // word[i] = (i+1) << 8
    localparam int PAT_ONES  = 2;  // all ones
    localparam int PAT_IDX   = 3;  // word[i] = i
    localparam int PAT_RAND  = 4;

    logic          clk;
    logic          rst_LBFGS;
    logic          valid_LBFGS;
    logic [DW-1:0] result_LBFGS [NW];
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          chk_valid;
    logic [DW-1:0] chk_data;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    logic [DW-1:0] frame_words [NW];

    lbfgs_result_unloader #(
        .NUM_WORDS (NW),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst_LBFGS   (rst_LBFGS),
        .valid_LBFGS (valid_LBFGS),
        .result_LBFGS(result_LBFGS),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last),
        .busy        (busy),
        .chk_valid   (chk_valid),
        .chk_data    (chk_data),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            pat;
        int            rmode;      // 0: always ready, 1: toggle 1,0,1.., 2: random
        int            ovr_at;     // index at which to inject a dropped pulse, -1 none
        bit            ovr_done;   // inject a pulse during the DONE cycle
        bit            iso;        // scramble result_LBFGS after capture
        bit            rst_before;
        logic [DW-1:0] exp_chk;
        bit            exp_ovr;
    } frame_vec_t;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (frame %0d): got %h expected %h", name, frame_no, act, exp);
        end
    endfunction

    function automatic void fill_words(int pat);
        for (int i = 0; i < NW; i++) begin
            case (pat)
                PAT_INC:   frame_words[i] = DW'(i + 1);
                PAT_SHIFT: frame_words[i] = DW'(i + 1) << 8;
                PAT_ONES:  frame_words[i] = '1;
                PAT_IDX:   frame_words[i] = DW'(i);
                default:   frame_words[i] = {$urandom, $urandom};
            endcase
        end
    endfunction

    task automatic do_reset();
        rst_LBFGS   = 1'b0;
        valid_LBFGS = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        rst_LBFGS = 1'b1;
        @(negedge clk);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_frame(input int rmode, input int ovr_at, input bit ovr_done,
                             input bit iso, input logic [DW-1:0] exp_chk, input bit exp_ovr);
        int  idx;
        int  cyc;
        bit  injected;
        result_LBFGS = frame_words;
        valid_LBFGS  = 1'b1;
        out_ready    = 1'b0;
        @(negedge clk);
        valid_LBFGS = 1'b0;
        idx = 0;
        cyc = 0;
        injected = 1'b0;
        while (idx < NW && cyc < 1000) begin
            check("busy_send", busy, 1);
            check("out_valid_send", out_valid, 1);
            check("out_addr", out_addr, idx);
            check("out_data", out_data, frame_words[idx]);
            check("out_last", out_last, idx == NW - 1);
            check("chk_valid_send", chk_valid, 0);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            valid_LBFGS = (ovr_at == idx) && !injected;
            if (valid_LBFGS) injected = 1'b1;
            if (iso) begin
                for (int i = 0; i < NW; i++) result_LBFGS[i] = ~frame_words[i];
            end
            if (out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        check("frame_complete", idx, NW);
        if (rmode == 0) check("send_cycles", cyc, NW);
        valid_LBFGS = ovr_done;
        out_ready   = 1'($urandom_range(0, 1));
        check("chk_valid_done", chk_valid, 1);
        check("chk_data_done", chk_data, exp_chk);
        check("out_valid_done", out_valid, 0);
        check("busy_done", busy, 1);
        @(negedge clk);
        valid_LBFGS = 1'b0;
        out_ready   = 1'b0;
        check("chk_valid_idle", chk_valid, 0);
        check("busy_idle", busy, 0);
        check("out_valid_idle", out_valid, 0);
        check("chk_data_hold", chk_data, exp_chk);
        check("overrun", overrun, exp_ovr);
        $display("frame %0d: words=%0d cycles=%0d chk_data=%h overrun=%b",
                 frame_no, idx, cyc + 1, chk_data, overrun);
        frame_no++;
    endtask

    initial begin
        frame_vec_t    vecs [11];
        logic [DW-1:0] xr;
        bit            model_ovr;
        int            n;

        vecs[0]  = '{PAT_INC,   0, -1, 0, 0, 0, 64'h34,   0};
        vecs[1]  = '{PAT_INC,   1, -1, 0, 0, 0, 64'h34,   0};
        vecs[2]  = '{PAT_INC,   0, -1, 0, 1, 0, 64'h34,   0};
        vecs[3]  = '{PAT_SHIFT, 0, -1, 0, 0, 0, 64'h3400, 0};
        vecs[4]  = '{PAT_ONES,  1, -1, 0, 0, 0, 64'h0,    0};
        vecs[5]  = '{PAT_IDX,   2, -1, 0, 0, 0, 64'h0,    0};
        vecs[6]  = '{PAT_INC,   0, 10, 0, 0, 0, 64'h34,   1};
        vecs[7]  = '{PAT_INC,   0, -1, 0, 0, 0, 64'h34,   1};
        vecs[8]  = '{PAT_INC,   0, 51, 0, 0, 1, 64'h34,   1};
        vecs[9]  = '{PAT_SHIFT, 1, -1, 1, 0, 1, 64'h3400, 1};
        vecs[10] = '{PAT_INC,   0, -1, 0, 0, 1, 64'h34,   0};

        rst_LBFGS   = 1'b0;
        valid_LBFGS = 1'b0;
        out_ready   = 1'b0;
        for (int i = 0; i < NW; i++) result_LBFGS[i] = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_chk_data", chk_data, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_LBFGS = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].rst_before) do_reset();
            fill_words(vecs[v].pat);
            run_frame(vecs[v].rmode, vecs[v].ovr_at, vecs[v].ovr_done, vecs[v].iso,
                      vecs[v].exp_chk, vecs[v].exp_ovr);
        end

        // Reset asserted mid-frame at out_addr 20
        fill_words(PAT_INC);
        result_LBFGS = frame_words;
        valid_LBFGS  = 1'b1;
        @(negedge clk);
        valid_LBFGS = 1'b0;
        out_ready   = 1'b1;
        n = 0;
        while (out_addr != AW'(20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_addr20", out_addr, 20);
        #2 rst_LBFGS = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_addr", out_addr, 0);
        check("arst_out_last", out_last, 0);
        check("arst_busy", busy, 0);
        check("arst_chk_valid", chk_valid, 0);
        check("arst_chk_data", chk_data, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_chk", chk_valid, 0);
        end
        out_ready = 1'b0;
        rst_LBFGS = 1'b1;
        @(negedge clk);
        run_frame(0, -1, 0, 0, 64'h34, 0);

        // Random frames against the scoreboard
        model_ovr = 1'b0;
        for (int f = 0; f < 200; f++) begin
            int ovr_at;
            bit ovr_done;
            int gap;
            if (f % 25 == 0) begin
                do_reset();
                model_ovr = 1'b0;
            end
            fill_words(PAT_RAND);
            xr = '0;
            for (int i = 0; i < NW; i++) xr = xr ^ frame_words[i];
            ovr_at    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
            ovr_done  = ($urandom_range(0, 7) == 0);
            model_ovr = model_ovr | (ovr_at >= 0) | ovr_done;
            run_frame(2, ovr_at, ovr_done, 1'($urandom_range(0, 1)), xr, model_ovr);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("gap_out_valid", out_valid, 0);
                check("gap_busy", busy, 0);
            end
            out_ready = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
